pmr_reduce_pipe: RTL and testbench
==================================

Name: pmr_reduce_pipe

Overview:
- Parametrised, fully pipelined pseudo-Mersenne modular reducer.
- Modulus p = 2^K - C.
- Takes an IN_W-bit product and returns the canonical residue in [0, p).
- Folds run as valid/ready-handshaked pipeline stages so the block drops in behind the multiplier array and stalls cleanly under backpressure.
- Successor to the fixed 2-stage K=24/C=63 reducer: adds generic K/C/IN_W, a configurable fold count, a final canonical correction and flow control.

Parameters:
- IN_W, 70, input operand width in bits.
- K, 24, modulus exponent; output width.
- C, 63, modulus offset; p = 2^K - C; legal range 1 <= C < 2^(K-1).
- FOLDS, 4, number of fold stages before the final correction stage.
- TAG_W, 4, sideband tag width; used only when PMR_TAG_EN is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word this cycle.
- in_data  in  IN_W  value to reduce, any value in [0, 2^IN_W).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_res  out  K  in_data mod p, canonical.
- in_tag  in  TAG_W  sideband tag (PMR_TAG_EN only).
- out_tag  out  TAG_W  tag aligned with out_res (PMR_TAG_EN only).

Behaviour:
- Clock and reset are decided: one clock, clk; reset rst_n is synchronous and active-low. Sampled only on the rising edge of clk.
- Reset effects:
  - All stage valid bits clear.
  - out_valid = 0, out_res = 0, out_tag = 0.
  - All stage data registers clear to 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Reset mid-operation: every in-flight word is discarded and nothing is emitted afterwards.
- Pipeline shape: FOLDS fold stages, then 1 correction stage. Latency is FOLDS+1 cycles from input acceptance to out_valid with no stall (5 at defaults). Throughput is 1 word per cycle.
- Fold stage i: v_{i+1} = v_i[K-1:0] + C * v_i[W_i-1:K].
  - The multiply by C is a constant multiply; synthesis may use shift/add.
  - Stage width: W_0 = IN_W; W_{i+1} = max(K, W_i - K + clog2(C+1)) + 1.
  - Stage arithmetic is unsigned with no truncation.
- Correction stage: out_res = (v_F >= p) ? v_F - p : v_F, where v_F is the last fold output.
- Elaboration check: the maximum of v_F must be < 2p; otherwise $fatal. At defaults the bound on v_F is 2^24 + 62.
- Handshake:
  - Each stage register loads when its upstream is valid and (the stage is empty, or its own downstream accepts).
  - Stage ready = !stage_valid || next_stage_ready.
  - in_ready = stage-0 ready; it is combinational from out_ready through the ready chain.
  - A transfer occurs when valid && ready on the same edge.
- Output hold: while out_valid && !out_ready, out_res and out_tag hold stable. Upstream stages continue filling their empty slots; once full, in_ready = 0.
- Simultaneous output drain and input accept in the same cycle, pipeline full: both occur, occupancy unchanged, no bubble.
- No reordering and no drop: outputs appear in input order.

Optional Feature:
- Macro: PMR_TAG_EN.
- Defined: in_tag and out_tag ports exist; the tag is registered alongside the data in every stage and emerges with its result under the same handshake.
- Undefined: tag ports and tag registers are absent; all other behaviour is identical.

Decomposition:
- Package pmr_pkg holds:
  - function pmr_stage_w(i), per-stage width;
  - function pmr_modulus(), returns 2^K - C;
  - function pmr_fold_bound(), worst-case v_F used by the elaboration check;
  - localparam OUT_W = K.
- Sub-module pmr_fold_stage: one fold plus its valid/data/tag register and ready logic, parametrised by W_IN and W_OUT. Instantiated FOLDS times in a generate loop; the correction stage is inline in the top level.

Test Plan (defaults; p = 16777153):
- Single words, out_ready = 1:
  - in_data = 0 -> out_res = 0 after 5 cycles.
  - in_data = 16777153 -> 0.
  - in_data = 16777152 -> 16777152.
- in_data = 2^24 -> 63; in_data = 2^70-1 -> 4256799; in_data = 2^48 -> 3969.
- Streaming: 1000 random 70-bit words back-to-back, out_ready = 1 -> one result per cycle, in order, each equal to a golden-model mod p; in_ready stays 1.
- Backpressure: hold out_ready = 0 for 10 cycles during a stream.
  - in_ready drops after 5 accepted words.
  - out_res is stable while stalled.
  - When out_ready returns to 1, no word is lost or duplicated.
- Reset mid-stream: assert rst_n = 0 for 1 cycle with 3 words in flight -> next cycle out_valid = 0, out_res = 0; no stale outputs afterwards; a new word 2^24 -> 63.
- PMR_TAG_EN: stream tags 0..15 with random data under random out_ready -> each out_tag matches its input word's tag.

Source files
------------

// File: rtl/pmr_pkg.sv
// Shared helpers for the pseudo-Mersenne reducer: per-fold widths, the modulus
// and the worst-case last-fold value used to prove one correction is enough.
package pmr_pkg;

    localparam int PMR_IN_W  = 70;
    localparam int PMR_K     = 24;
    localparam int PMR_C     = 63;
    localparam int PMR_FOLDS = 4;
    localparam int PMR_TAG_W = 4;
    localparam int OUT_W     = PMR_K;

    localparam int CALC_W = 128;
    typedef logic [CALC_W-1:0] pmr_calc_t;

    // Width of the value entering fold i (i = 0 is the raw input).
    function automatic int pmr_stage_w(input int i, input int in_w, input int k, input int c);
        int w;
        int hi_w;
        w = in_w;
        for (int s = 0; s < i; s++) begin
            hi_w = w - k + $clog2(c + 1);
            w    = ((hi_w > k) ? hi_w : k) + 1;
        end
        return w;
    endfunction

    function automatic pmr_calc_t pmr_modulus(input int k, input int c);
        return (pmr_calc_t'(1) << k) - pmr_calc_t'(c);
    endfunction

    // Treats low and high halves as independently maximal, so it over-estimates.
    function automatic pmr_calc_t pmr_fold_bound(input int in_w, input int k, input int c,
                                                 input int folds);
        pmr_calc_t m;
        pmr_calc_t lo_max;
        pmr_calc_t lo;
        pmr_calc_t hi;
        m      = (pmr_calc_t'(1) << in_w) - pmr_calc_t'(1);
        lo_max = (pmr_calc_t'(1) << k) - pmr_calc_t'(1);
        for (int s = 0; s < folds; s++) begin
            lo = (m < lo_max) ? m : lo_max;
            hi = m >> k;
            m  = lo + pmr_calc_t'(c) * hi;
        end
        return m;
    endfunction

endpackage

// File: rtl/pmr_fold_stage.sv
// One fold v' = v[K-1:0] + C*v[W_IN-1:K] with its valid/data register and
// ready logic. Tag sideband exists only when PMR_TAG_EN is defined.
module pmr_fold_stage
    import pmr_pkg::*;
#(
    parameter int K     = OUT_W,
    parameter int C     = PMR_C,
    parameter int W_IN  = PMR_IN_W,
    parameter int W_OUT = pmr_stage_w(1, W_IN, K, C)
`ifdef PMR_TAG_EN
    , parameter int TAG_W = PMR_TAG_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W_IN-1:0]  i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W_OUT-1:0] o_data
`ifdef PMR_TAG_EN
    , input  logic [TAG_W-1:0] i_tag
    , output logic [TAG_W-1:0] o_tag
`endif
);

    logic             r_valid;
    logic [W_OUT-1:0] r_data;
    logic [W_OUT-1:0] w_fold;

    // W_OUT is sized so this sum can never overflow.
    assign w_fold  = W_OUT'(i_data[K-1:0]) + W_OUT'(C) * W_OUT'(i_data[W_IN-1:K]);
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_fold;
            end
        end
    end

`ifdef PMR_TAG_EN
    logic [TAG_W-1:0] r_tag;
    assign o_tag = r_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else if (o_ready && i_valid) begin
            r_tag <= i_tag;
        end
    end
`endif

endmodule

// File: rtl/pmr_reduce_pipe.sv
// Pipelined reducer mod p = 2^K - C: FOLDS handshaked fold stages then one
// conditional-subtract stage. Define PMR_TAG_EN to carry a tag with each word.
module pmr_reduce_pipe
    import pmr_pkg::*;
#(
    parameter int IN_W  = PMR_IN_W,
    parameter int K     = OUT_W,
    parameter int C     = PMR_C,
    parameter int FOLDS = PMR_FOLDS,
    parameter int TAG_W = PMR_TAG_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [K-1:0]    out_res
`ifdef PMR_TAG_EN
    , input  logic [TAG_W-1:0] in_tag
    , output logic [TAG_W-1:0] out_tag
`endif
);

    localparam int            WF  = pmr_stage_w(FOLDS, IN_W, K, C);
    localparam logic [WF-1:0] P_F = WF'(pmr_modulus(K, C));

    if (FOLDS < 1 || IN_W <= K || C < 1 || C >= (1 << (K - 1)) || TAG_W < 1) begin : g_bad_param
        $fatal(1, "pmr_reduce_pipe: illegal parameter combination");
    end

    // A single conditional subtract only canonicalises values below 2p.
    if (pmr_fold_bound(IN_W, K, C, FOLDS) >= (pmr_modulus(K, C) << 1)) begin : g_bad_bound
        $fatal(1, "pmr_reduce_pipe: FOLDS too small, last fold may reach 2p");
    end

    logic          w_corr_ready;
    logic          w_vf_valid;
    logic [WF-1:0] w_vf;
    logic [K-1:0]  w_corr;
    logic          r_out_valid;
    logic [K-1:0]  r_out_res;

    genvar gi;
    for (gi = 0; gi < FOLDS; gi++) begin : g_fold
        localparam int WI = pmr_stage_w(gi, IN_W, K, C);
        localparam int WO = pmr_stage_w(gi + 1, IN_W, K, C);

        logic          w_up_valid;
        logic          w_up_ready;
        logic [WI-1:0] w_d_in;
        logic          w_dn_valid;
        logic          w_dn_ready;
        logic [WO-1:0] w_d_out;
`ifdef PMR_TAG_EN
        logic [TAG_W-1:0] w_tag_in;
        logic [TAG_W-1:0] w_tag_out;
`endif

        if (gi == 0) begin : g_src
            assign w_up_valid = in_valid;
            assign w_d_in     = in_data;
`ifdef PMR_TAG_EN
            assign w_tag_in   = in_tag;
`endif
        end else begin : g_src
            assign w_up_valid = g_fold[gi-1].w_dn_valid;
            assign w_d_in     = g_fold[gi-1].w_d_out;
`ifdef PMR_TAG_EN
            assign w_tag_in   = g_fold[gi-1].w_tag_out;
`endif
        end

        if (gi == FOLDS - 1) begin : g_sink
            assign w_dn_ready = w_corr_ready;
        end else begin : g_sink
            assign w_dn_ready = g_fold[gi+1].w_up_ready;
        end

        pmr_fold_stage #(
            .K     (K),
            .C     (C),
            .W_IN  (WI),
            .W_OUT (WO)
`ifdef PMR_TAG_EN
            , .TAG_W (TAG_W)
`endif
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_up_valid),
            .o_ready (w_up_ready),
            .i_data  (w_d_in),
            .o_valid (w_dn_valid),
            .i_ready (w_dn_ready),
            .o_data  (w_d_out)
`ifdef PMR_TAG_EN
            , .i_tag (w_tag_in)
            , .o_tag (w_tag_out)
`endif
        );
    end

    assign in_ready   = g_fold[0].w_up_ready;
    assign w_vf_valid = g_fold[FOLDS-1].w_dn_valid;
    assign w_vf       = g_fold[FOLDS-1].w_d_out;

    assign w_corr       = (w_vf >= P_F) ? K'(w_vf - P_F) : K'(w_vf);
    assign w_corr_ready = !r_out_valid || out_ready;
    assign out_valid    = r_out_valid;
    assign out_res      = r_out_res;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
        end else if (w_corr_ready) begin
            r_out_valid <= w_vf_valid;
            if (w_vf_valid) begin
                r_out_res <= w_corr;
            end
        end
    end

`ifdef PMR_TAG_EN
    logic [TAG_W-1:0] r_out_tag;
    assign out_tag = r_out_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_tag <= '0;
        end else if (w_corr_ready && w_vf_valid) begin
            r_out_tag <= g_fold[FOLDS-1].w_tag_out;
        end
    end
`endif

endmodule

// File: tb/tb_pmr_reduce_pipe.sv
// Self-checking bench for pmr_reduce_pipe: results are compared against
// in_data % p kept in an in-order scoreboard queue.
module tb_pmr_reduce_pipe;

    localparam int IN_W  = 70;
    localparam int K     = 24;
    localparam int C     = 63;
    localparam int FOLDS = 4;
    localparam int TAG_W = 4;
    localparam logic [IN_W-1:0] P_M = (IN_W'(1) << K) - IN_W'(C);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [K-1:0]    out_res;
`ifdef PMR_TAG_EN
    logic [TAG_W-1:0] in_tag;
    logic [TAG_W-1:0] out_tag;
    logic [TAG_W-1:0] obs_tag;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [K-1:0] exp_q[$];
`ifdef PMR_TAG_EN
    logic [TAG_W-1:0] tag_q[$];
`endif

    always #5 clk = ~clk;

    pmr_reduce_pipe #(
        .IN_W  (IN_W),
        .K     (K),
        .C     (C),
        .FOLDS (FOLDS),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
`ifdef PMR_TAG_EN
        , .in_tag  (in_tag)
        , .out_tag (out_tag)
`endif
    );

    function automatic logic [K-1:0] ref_mod(input logic [IN_W-1:0] x);
        return K'(x % P_M);
    endfunction

    function automatic logic [IN_W-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return P_M;
            2:       return P_M - IN_W'(1);
            3:       return IN_W'(r[40:0]) * P_M;
            default: return IN_W'(r);
        endcase
    endfunction

    // Called just after a falling edge; drives one cycle, samples outputs
    // 1 time unit later and returns at the next falling edge.
    task automatic drive_cycle(input logic v, input logic [IN_W-1:0] d, input logic ordy,
                               output logic acc, output logic ovld,
                               output logic [K-1:0] ores, output logic rdy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        rdy  = in_ready;
        acc  = v && in_ready;
        ovld = out_valid;
        ores = out_res;
`ifdef PMR_TAG_EN
        obs_tag = out_tag;
`endif
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_res !== '0) $display("FAIL reset_out_res: got %0d expected 0", out_res);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [IN_W-1:0] din [6];
        logic [K-1:0]    dexp[6];
        logic            acc, ovld, rdy, found;
        logic [K-1:0]    ores, got;
        int              lat;
        din[0] = '0;                 dexp[0] = 24'd0;
        din[1] = P_M;                dexp[1] = 24'd0;
        din[2] = P_M - IN_W'(1);     dexp[2] = 24'd16777152;
        din[3] = IN_W'(1) << 24;     dexp[3] = 24'd63;
        din[4] = '1;                 dexp[4] = 24'd4256799;
        din[5] = IN_W'(1) << 48;     dexp[5] = 24'd3969;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, din[i], 1'b1, acc, ovld, ores, rdy);
            n_checks++;
            if (acc !== 1'b1) $display("FAIL dir_accept[%0d]: got %b expected 1", i, acc);
            else n_pass++;
            found = 1'b0;
            lat   = 99;
            got   = '0;
            for (int c = 1; c <= 12 && !found; c++) begin
                drive_cycle(1'b0, '0, 1'b1, acc, ovld, ores, rdy);
                if (ovld) begin
                    found = 1'b1;
                    lat   = c;
                    got   = ores;
                end
            end
            n_checks++;
            if (lat != 5) $display("FAIL dir_latency[%0d]: got %0d expected 5", i, lat);
            else n_pass++;
            n_checks++;
            if (got !== dexp[i]) $display("FAIL dir_result[%0d]: got %0d expected %0d", i, got, dexp[i]);
            else n_pass++;
            $display("directed %0d: in=%0h res=%0d latency=%0d", i, din[i], got, lat);
        end
    endtask

    task automatic test_stream();
        logic            v, acc, ovld, rdy;
        logic [IN_W-1:0] d;
        logic [K-1:0]    ores, e;
        int sent = 0, recv = 0, stalls = 0, first = -1, last = -1;
        exp_q.delete();
        for (int c = 0; c < 1200 && (sent < 1000 || exp_q.size() > 0); c++) begin
            v = (sent < 1000);
            d = rand_word();
            drive_cycle(v, d, 1'b1, acc, ovld, ores, rdy);
            if (v && !rdy) stalls++;
            if (ovld) begin
                if (first < 0) first = c;
                last = c;
                recv++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_result: got %0d expected none (unexpected output)", ores);
                end else begin
                    e = exp_q.pop_front();
                    if (ores !== e) $display("FAIL stream_result[%0d]: got %0d expected %0d", recv - 1, ores, e);
                    else n_pass++;
                end
            end
            if (acc) begin
                exp_q.push_back(ref_mod(d));
                sent++;
            end
        end
        n_checks++;
        if (stalls != 0) $display("FAIL stream_in_ready: got %0d stall cycles expected 0", stalls);
        else n_pass++;
        n_checks++;
        if (recv != 1000) $display("FAIL stream_count: got %0d expected 1000", recv);
        else n_pass++;
        n_checks++;
        if (last - first + 1 != 1000) $display("FAIL stream_gapless: got span %0d expected 1000", last - first + 1);
        else n_pass++;
        $display("stream: sent=%0d recv=%0d span=%0d", sent, recv, last - first + 1);
    endtask

    task automatic test_backpressure();
        logic            acc, ovld, rdy;
        logic [IN_W-1:0] d;
        logic [K-1:0]    ores, e;
        int sent = 0, recv = 0;
        exp_q.delete();
        for (int j = 0; j < 10; j++) begin
            d = rand_word();
            drive_cycle(1'b1, d, 1'b0, acc, ovld, ores, rdy);
            n_checks++;
            if (rdy !== (j < 5)) $display("FAIL bp_in_ready[%0d]: got %b expected %b", j, rdy, (j < 5));
            else n_pass++;
            if (j >= 5) begin
                n_checks++;
                if (ovld !== 1'b1 || exp_q.size() == 0 || ores !== exp_q[0])
                    $display("FAIL bp_hold[%0d]: got valid=%b res=%0d expected valid=1 res=%0d",
                             j, ovld, ores, (exp_q.size() > 0) ? exp_q[0] : '0);
                else n_pass++;
            end
            if (acc) begin
                exp_q.push_back(ref_mod(d));
                sent++;
            end
        end
        n_checks++;
        if (sent != 5) $display("FAIL bp_accepted: got %0d expected 5", sent);
        else n_pass++;
        for (int c = 0; c < 200 && (sent < 25 || exp_q.size() > 0); c++) begin
            d = rand_word();
            drive_cycle(sent < 25, d, 1'b1, acc, ovld, ores, rdy);
            if (ovld) begin
                recv++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bp_result: got %0d expected none (duplicate output)", ores);
                end else begin
                    e = exp_q.pop_front();
                    if (ores !== e) $display("FAIL bp_result[%0d]: got %0d expected %0d", recv - 1, ores, e);
                    else n_pass++;
                end
            end
            if (acc) begin
                exp_q.push_back(ref_mod(d));
                sent++;
            end
        end
        n_checks++;
        if (recv != 25 || exp_q.size() != 0)
            $display("FAIL bp_count: got %0d outputs (%0d pending) expected 25", recv, exp_q.size());
        else n_pass++;
        $display("backpressure: sent=%0d recv=%0d", sent, recv);
    endtask

    task automatic test_random_flow();
        logic            v, ordy, acc, ovld, rdy, prev_stall;
        logic [IN_W-1:0] d;
        logic [K-1:0]    ores, e, prev_res;
        int sent = 0, recv = 0;
        exp_q.delete();
        prev_stall = 1'b0;
        prev_res   = '0;
        for (int c = 0; c < 4000 && (sent < 300 || exp_q.size() > 0); c++) begin
            v    = (sent < 300) && ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            d    = rand_word();
            drive_cycle(v, d, ordy, acc, ovld, ores, rdy);
            if (prev_stall) begin
                n_checks++;
                if (ovld !== 1'b1 || ores !== prev_res)
                    $display("FAIL flow_hold: got valid=%b res=%0d expected valid=1 res=%0d", ovld, ores, prev_res);
                else n_pass++;
            end
            if (ovld && ordy) begin
                recv++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL flow_result: got %0d expected none (unexpected output)", ores);
                end else begin
                    e = exp_q.pop_front();
                    if (ores !== e) $display("FAIL flow_result[%0d]: got %0d expected %0d", recv - 1, ores, e);
                    else n_pass++;
                end
            end
            prev_stall = ovld && !ordy;
            prev_res   = ores;
            if (acc) begin
                exp_q.push_back(ref_mod(d));
                sent++;
            end
        end
        n_checks++;
        if (recv != 300 || exp_q.size() != 0)
            $display("FAIL flow_count: got %0d outputs (%0d pending) expected 300", recv, exp_q.size());
        else n_pass++;
        $display("random flow: sent=%0d recv=%0d", sent, recv);
    endtask

    task automatic test_reset_midstream();
        logic         acc, ovld, rdy, found;
        logic [K-1:0] ores, got;
        int           stale = 0, lat = 99;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, rand_word(), 1'b1, acc, ovld, ores, rdy);
        end
        rst_n = 1'b0;
        drive_cycle(1'b0, '0, 1'b1, acc, ovld, ores, rdy);
        rst_n = 1'b1;
        drive_cycle(1'b0, '0, 1'b1, acc, ovld, ores, rdy);
        n_checks++;
        if (ovld !== 1'b0 || ores !== '0)
            $display("FAIL midreset_clear: got valid=%b res=%0d expected valid=0 res=0", ovld, ores);
        else n_pass++;
        n_checks++;
        if (rdy !== 1'b1) $display("FAIL midreset_in_ready: got %b expected 1", rdy);
        else n_pass++;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b0, '0, 1'b1, acc, ovld, ores, rdy);
            if (ovld) stale++;
        end
        n_checks++;
        if (stale != 0) $display("FAIL midreset_stale: got %0d stale outputs expected 0", stale);
        else n_pass++;
        drive_cycle(1'b1, IN_W'(1) << 24, 1'b1, acc, ovld, ores, rdy);
        found = 1'b0;
        got   = '0;
        for (int c = 1; c <= 12 && !found; c++) begin
            drive_cycle(1'b0, '0, 1'b1, acc, ovld, ores, rdy);
            if (ovld) begin
                found = 1'b1;
                lat   = c;
                got   = ores;
            end
        end
        n_checks++;
        if (lat != 5 || got !== 24'd63)
            $display("FAIL midreset_new_word: got res=%0d latency=%0d expected res=63 latency=5", got, lat);
        else n_pass++;
        $display("reset midstream: stale=%0d new_res=%0d", stale, got);
    endtask

`ifdef PMR_TAG_EN
    task automatic test_tags();
        logic            ordy, acc, ovld, rdy;
        logic [IN_W-1:0] d;
        logic [K-1:0]    ores, e;
        logic [TAG_W-1:0] et;
        int sent = 0, recv = 0;
        exp_q.delete();
        tag_q.delete();
        for (int c = 0; c < 500 && (sent < 16 || exp_q.size() > 0); c++) begin
            ordy   = ($urandom_range(0, 1) == 1);
            d      = rand_word();
            in_tag = TAG_W'(sent);
            drive_cycle(sent < 16, d, ordy, acc, ovld, ores, rdy);
            if (ovld && ordy) begin
                recv++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL tag_result: got tag %0d expected none", obs_tag);
                end else begin
                    e  = exp_q.pop_front();
                    et = tag_q.pop_front();
                    if (obs_tag !== et || ores !== e)
                        $display("FAIL tag_result: got tag=%0d res=%0d expected tag=%0d res=%0d", obs_tag, ores, et, e);
                    else n_pass++;
                end
            end
            if (acc) begin
                exp_q.push_back(ref_mod(d));
                tag_q.push_back(TAG_W'(sent));
                sent++;
            end
        end
        n_checks++;
        if (recv != 16) $display("FAIL tag_count: got %0d expected 16", recv);
        else n_pass++;
        $display("tags: sent=%0d recv=%0d", sent, recv);
    endtask
`endif

    initial begin
`ifdef PMR_TAG_EN
        in_tag = '0;
`endif
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_random_flow();
        test_reset_midstream();
`ifdef PMR_TAG_EN
        test_tags();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
